// File: rtl/platform_scan.sv
// platform_scan: per-frame broad-phase AABB scan of a small platform table against the player box.
module platform_scan #(
  parameter int NUM_PLAT = 4,
  parameter int W1 = 23,
  parameter int H1 = 30,
  parameter int W2 = 30,
  parameter int H2 = 40,
  parameter int IDXW = $clog2(NUM_PLAT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_tick,
  input  logic signed [9:0]      px,
  input  logic signed [9:0]      py,
  input  logic                   cfg_we,
  input  logic [IDXW-1:0]        cfg_idx,
  input  logic signed [9:0]      cfg_x,
  input  logic signed [9:0]      cfg_y,
  input  logic                   cfg_valid,
  output logic signed [9:0]      x2,
  output logic signed [9:0]      y2,
  output logic                   collision,
  output logic [IDXW-1:0]        hit_idx,
  output logic                   done,
  output logic                   busy,
  output logic                   overrun
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_nx;
  logic signed [9:0] tx [NUM_PLAT];
  logic signed [9:0] ty [NUM_PLAT];
  logic [NUM_PLAT-1:0] tv;
  logic signed [9:0] spx, spy;
  logic [IDXW-1:0] scan_idx;
  logic signed [10:0] ex, ey, sx, sy;
  logic hit, last, finish;
  // sign-extend to 11 bits so the box-edge sums cannot wrap
  always_comb begin
    ex = {tx[scan_idx][9], tx[scan_idx]};
    ey = {ty[scan_idx][9], ty[scan_idx]};
    sx = {spx[9], spx};
    sy = {spy[9], spy};
    hit = tv[scan_idx] && (sx < ex + 11'(W2)) && (sx + 11'(W1) > ex)
                       && (sy < ey + 11'(H2)) && (sy + 11'(H1) > ey);
    last = scan_idx == IDXW'(NUM_PLAT - 1);
    finish = (state == SCAN) && (hit || last);
    state_nx = (state == IDLE) ? (frame_tick ? SCAN : IDLE) : (finish ? IDLE : SCAN);
  end
  assign busy = state == SCAN;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        tx[i] <= '0;
        ty[i] <= '0;
      end
      tv <= '0;
      spx <= '0;
      spy <= '0;
      scan_idx <= '0;
      x2 <= '0;
      y2 <= '0;
      collision <= 1'b0;
      hit_idx <= '0;
      done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (cfg_we) begin
        tx[cfg_idx] <= cfg_x;
        ty[cfg_idx] <= cfg_y;
        tv[cfg_idx] <= cfg_valid;
      end
      done <= finish;
      if (frame_tick && state == SCAN) overrun <= 1'b1;
      if (state == IDLE && frame_tick) begin
        spx <= px;
        spy <= py;
        scan_idx <= '0;
      end else if (state == SCAN && !finish) scan_idx <= scan_idx + 1'b1;
      if (finish) collision <= hit;
      // a miss leaves the previous hit coordinates in place
      if (finish && hit) begin
        x2 <= tx[scan_idx];
        y2 <= ty[scan_idx];
        hit_idx <= scan_idx;
      end
    end
  end
endmodule

// File: tb/tb_platform_scan.sv
// tb_platform_scan: directed plus random frames checked each cycle against a frame-level reference model.
module tb_platform_scan;
  localparam int NUM = 4;
  logic clk = 1'b0, rst_n = 1'b1, frame_tick = 1'b0, cfg_we = 1'b0, cfg_valid = 1'b0;
  logic signed [9:0] px = '0, py = '0, cfg_x = '0, cfg_y = '0;
  logic [1:0] cfg_idx = '0;
  logic signed [9:0] x2, y2;
  logic collision, done, busy, overrun;
  logic [1:0] hit_idx;
  int checks = 0, errors = 0;
  int mtx [NUM] = '{default: 0};
  int mty [NUM] = '{default: 0};
  bit mtv [NUM] = '{default: 0};
  int m_left = 0, m_w = -1, e_x2 = 0, e_y2 = 0, e_hit = 0;
  bit e_col = 0, e_done = 0, e_ovr = 0;

  platform_scan dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .px(px), .py(py),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_valid(cfg_valid),
    .x2(x2), .y2(y2), .collision(collision), .hit_idx(hit_idx), .done(done),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic signed [31:0] a, input logic signed [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask

  function automatic bit overlaps(int sx, int sy, int x, int y, bit v);
    return v && sx < x + 30 && sx + 23 > x && sy < y + 40 && sy + 30 > y;
  endfunction

  // frame-level model: the winner is chosen when the tick is accepted, then published after its latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) begin
        mtx[i] = 0; mty[i] = 0; mtv[i] = 0;
      end
      m_left = 0; m_w = -1; e_x2 = 0; e_y2 = 0; e_hit = 0; e_col = 0; e_done = 0; e_ovr = 0;
    end else begin
      e_done = 0;
      if (m_left > 0) begin
        if (frame_tick) e_ovr = 1;
        m_left--;
        if (m_left == 0) begin
          e_done = 1;
          e_col = m_w >= 0;
          if (m_w >= 0) begin
            e_x2 = mtx[m_w]; e_y2 = mty[m_w]; e_hit = m_w;
          end
        end
      end else if (frame_tick) begin
        m_w = -1;
        for (int i = NUM - 1; i >= 0; i--)
          if (overlaps(int'(px), int'(py), mtx[i], mty[i], mtv[i])) m_w = i;
        m_left = m_w >= 0 ? m_w + 1 : NUM;
      end
      if (cfg_we) begin
        mtx[cfg_idx] = int'(cfg_x); mty[cfg_idx] = int'(cfg_y); mtv[cfg_idx] = cfg_valid;
      end
    end
  end

  always @(negedge clk) begin
    chk("collision", collision, e_col);
    chk("x2", x2, e_x2);
    chk("y2", y2, e_y2);
    chk("hit_idx", hit_idx, e_hit);
    chk("done", done, e_done);
    chk("busy", busy, m_left > 0);
    chk("overrun", overrun, e_ovr);
  end

  task automatic wr(input int idx, input int x, input int y, input bit v);
    @(negedge clk);
    cfg_we = 1; cfg_idx = 2'(idx); cfg_x = 10'(x); cfg_y = 10'(y); cfg_valid = v;
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NUM; i++) wr(i, 0, 0, 0);
  endtask

  task automatic tick(input int x, input int y);
    @(negedge clk);
    px = 10'(x); py = 10'(y); frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (m_left != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (m_left != 0) begin
      errors++;
      $display("FAIL scan_timeout got busy want idle");
    end
  endtask

  initial begin
    int n, r;
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_x2_lit", x2, 0);
    chk("rst_busy_lit", busy, 0);
    // hit at entry 0
    wr(0, 100, 200, 1);
    tick(90, 180);
    wait_res(n);
    chk("t2_lat", n, 1);
    chk("t2_done", done, 1);
    chk("t2_col", collision, 1);
    chk("t2_x2", x2, 100);
    chk("t2_y2", y2, 200);
    chk("t2_idx", hit_idx, 0);
    @(negedge clk);
    chk("t2_done_pulse", done, 0);
    // touching edges only
    tick(77, 180);
    wait_res(n);
    chk("t3_lat", n, 4);
    chk("t3_col", collision, 0);
    chk("t3_x2", x2, 100);
    chk("t3_y2", y2, 200);
    // lowest index wins
    clear_table();
    wr(1, 50, 50, 1);
    wr(3, 60, 60, 1);
    tick(55, 55);
    wait_res(n);
    chk("t4_lat", n, 2);
    chk("t4_idx", hit_idx, 1);
    chk("t4_x2", x2, 50);
    chk("t4_y2", y2, 50);
    // negative coordinates
    clear_table();
    wr(2, -10, -5, 1);
    tick(-20, -20);
    wait_res(n);
    chk("t5_col", collision, 1);
    chk("t5_x2", x2, -10);
    chk("t5_y2", y2, -5);
    chk("t5_idx", hit_idx, 2);
    // tick during a miss scan
    clear_table();
    tick(0, 0);
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    wait_res(n);
    chk("t6_lat", n, 3);
    chk("t6_ovr", overrun, 1);
    // tick coinciding with scan completion is dropped
    tick(0, 0);
    n = 0;
    while (m_left != 1 && n < 10) begin @(negedge clk); n++; end
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    chk("t6_late_tick_busy", busy, 0);
    // reset mid-scan
    wr(3, 0, 0, 1);
    tick(0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    @(negedge clk);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_ovr", overrun, 0);
    chk("t1_col", collision, 0);
    rst_n = 1;
    tick(0, 0);
    wait_res(n);
    chk("t1_table_cleared_lat", n, 4);
    chk("t1_table_cleared_col", collision, 0);
    // random frames
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      frame_tick = 0; cfg_we = 0;
      r = int'($urandom_range(9));
      px = 10'(int'($urandom_range(120)) - 60);
      py = 10'(int'($urandom_range(120)) - 60);
      if (r < 3) frame_tick = 1;
      else if (r < 6 && m_left == 0) begin
        cfg_we = 1;
        cfg_idx = 2'($urandom_range(3));
        cfg_x = 10'(int'($urandom_range(120)) - 60);
        cfg_y = 10'(int'($urandom_range(120)) - 60);
        cfg_valid = 1'($urandom_range(1));
      end
    end
    @(negedge clk);
    frame_tick = 0; cfg_we = 0;
    wait_res(n);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
